// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the ROM word address, captures returned words and buffers
// {pc, instr} pairs for decode. Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr_out,
  input  logic [31:0] imem_instr_in,
  input  logic        redirect_valid_in,
  input  logic [31:0] redirect_pc_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_misalign_out,
  input  logic        instr_ready_in
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]          fetch_pc;
  logic [31:0]          inflight_pc;
  logic                 inflight;
  logic [31:0]          buf_pc    [BUF_DEPTH];
  logic [31:0]          buf_instr [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] buf_mis;
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;
  logic [CW:0]          occupancy;
  logic                 pop;
  logic                 push;
  logic                 issue;
  logic                 halted;
  logic                 marker_pending;
  logic [31:0]          marker_pc;
  logic [31:0]          push_pc;
  logic [31:0]          push_instr;
  logic                 push_mis;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN, HALT} fetch_state_t;
  fetch_state_t state, state_next;

  // A misaligned redirect parks the unit in HALT and queues one marker entry for next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      marker_pending <= 1'b0;
      marker_pc      <= '0;
    end else begin
      state          <= state_next;
      marker_pending <= redirect_valid_in && (redirect_pc_in[1:0] != 2'b00);
      marker_pc      <= redirect_pc_in;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect_valid_in)
      state_next = (redirect_pc_in[1:0] != 2'b00) ? HALT : RUN;
  end

  assign halted = (state == HALT);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc_in[1:0];
  assign halted          = 1'b0;
  assign marker_pending  = 1'b0;
  assign marker_pc       = '0;
`endif

  assign pop       = instr_valid_out && instr_ready_in;
  assign occupancy = (CW+1)'(count) - (CW+1)'(pop) + (CW+1)'(inflight);
  assign issue     = !redirect_valid_in && !halted && (occupancy < (CW+1)'(BUF_DEPTH));

  // The marker and a returning word never coincide: HALT blocks issue, so inflight is clear.
  assign push       = inflight || marker_pending;
  assign push_pc    = marker_pending ? marker_pc : inflight_pc;
  assign push_instr = marker_pending ? 32'h0000_0013 : imem_instr_in;
  assign push_mis   = marker_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      buf_mis     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (redirect_valid_in) begin
      fetch_pc <= {redirect_pc_in[31:2], 2'b00};
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) begin
        buf_pc[tail]    <= push_pc;
        buf_instr[tail] <= push_instr;
        buf_mis[tail]   <= push_mis;
        tail            <= next_ptr(tail);
      end
      if (pop)
        head <= next_ptr(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign imem_addr_out      = fetch_pc;
  assign instr_valid_out    = (count != '0);
  assign instr_out          = buf_instr[head];
  assign instr_pc_out       = buf_pc[head];
  assign instr_misalign_out = buf_mis[head];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirects, wrap and
// the FETCH_MISALIGN_TRAP_EN marker (or realignment when the macro is undefined).
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr_out;
  logic [31:0] imem_instr_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;
  logic        instr_valid_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_misalign_out;
  logic        instr_ready_in;

  int vectors     = 0;
  int miscompares = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .imem_addr_out      (imem_addr_out),
    .imem_instr_in      (imem_instr_in),
    .redirect_valid_in  (redirect_valid_in),
    .redirect_pc_in     (redirect_pc_in),
    .instr_valid_out    (instr_valid_out),
    .instr_out          (instr_out),
    .instr_pc_out       (instr_pc_out),
    .instr_misalign_out (instr_misalign_out),
    .instr_ready_in     (instr_ready_in)
  );

  always #5 clk = ~clk;

  // ROM word i holds 0x1000_0000 + i; synchronous read, one cycle latency.
  function automatic logic [31:0] memWord(input logic [31:0] pc);
    return 32'h1000_0000 + {22'b0, pc[11:2]};
  endfunction

  always @(posedge clk) imem_instr_in <= memWord(imem_addr_out);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                               input logic rdy);
    reset             = rst;
    redirect_valid_in = redir;
    redirect_pc_in    = rpc;
    instr_ready_in    = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectStream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput("stream_valid", 32'(instr_valid_out), 32'd1);
      checkOutput("stream_pc", instr_pc_out, pc);
      checkOutput("stream_instr", instr_out, memWord(pc));
      checkOutput("stream_misalign", 32'(instr_misalign_out), 32'd0);
      pc = pc + 32'd4;
    end
  endtask

  task automatic expectIdle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag, 32'(instr_valid_out), 32'd0);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) tick();
    checkOutput("reset_valid", 32'(instr_valid_out), 32'd0);
    checkOutput("reset_addr", imem_addr_out, 32'h0000_0000);
    checkOutput("reset_instr", instr_out, 32'h0);
    checkOutput("reset_pc", instr_pc_out, 32'h0);
    checkOutput("reset_misalign", 32'(instr_misalign_out), 32'd0);

    // Streaming from reset: first valid two cycles after release, then one per cycle.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expectIdle("first_cycle_valid", 1);
    expectStream(32'h0, 4);

    // Backpressure: hold ready low for 5 cycles once pc 0 is at the head.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    tick();
    checkOutput("bp_first_valid", 32'(instr_valid_out), 32'd1);
    checkOutput("bp_first_pc", instr_pc_out, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_hold_pc", instr_pc_out, 32'h0);
      checkOutput("bp_addr_frozen", imem_addr_out, 32'h8);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expectStream(32'h4, 4);

    // Redirect to 0x40 with a full buffer and decode stalled.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("fill_head_pc", instr_pc_out, 32'h10);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
    tick();
    checkOutput("redir_flush_valid", 32'(instr_valid_out), 32'd0);
    checkOutput("redir_addr", imem_addr_out, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expectIdle("redir_gap_valid", 1);
    expectStream(32'h40, 3);

    // Redirect coinciding with a pop, then a second redirect that must win.
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b1);
    tick();
    checkOutput("redir1_valid", 32'(instr_valid_out), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h80, 1'b1);
    tick();
    checkOutput("redir2_valid", 32'(instr_valid_out), 32'd0);
    checkOutput("redir2_addr", imem_addr_out, 32'h80);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expectIdle("redir2_gap_valid", 1);
    expectStream(32'h80, 3);

    // Address wrap at the top of the 32-bit space.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expectIdle("wrap_gap_valid", 1);
    expectStream(32'hFFFF_FFF8, 3);

    // Misaligned redirect target.
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b1);
    tick();
    checkOutput("mis_flush_valid", 32'(instr_valid_out), 32'd0);
    checkOutput("mis_addr_aligned", imem_addr_out, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    checkOutput("marker_valid", 32'(instr_valid_out), 32'd1);
    checkOutput("marker_pc", instr_pc_out, 32'h42);
    checkOutput("marker_instr", instr_out, 32'h0000_0013);
    checkOutput("marker_flag", 32'(instr_misalign_out), 32'd1);
    expectIdle("halt_valid", 5);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expectIdle("halt_exit_gap", 1);
    expectStream(32'h100, 2);
`else
    expectIdle("mis_gap_valid", 1);
    expectStream(32'h40, 2);
`endif

    // Reset mid-stream overrides a simultaneous redirect.
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
    tick();
    checkOutput("midreset_valid", 32'(instr_valid_out), 32'd0);
    checkOutput("midreset_addr", imem_addr_out, 32'h0);
    checkOutput("midreset_pc", instr_pc_out, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    expectIdle("midreset_gap", 1);
    expectStream(32'h0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
